sd_spi_responder: RTL and testbench

- SPI mode-0 responder that emulates the SD-card end of the SPI link, clocked from the 27 MHz system clock.
- Oversamples the master's SCK/CS_n/MOSI, shifts bytes in and out, and frames 48-bit SD commands with CRC7 checking.
- Provides the device side for loopback benches and on-FPGA self-test of the SD SPI master path.

---
 rtl/sd_spi_responder.sv | 197 +++++++++++++++++++
 tb/tb_sd_spi_responder.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_spi_responder.sv
// SD-card side of an SPI mode-0 link: oversamples SCK/CS_n/MOSI on the system clock,
// moves bytes in and out, and frames 48-bit SD commands with CRC7 checking.
module sd_spi_responder #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_FILL   = 8'hFF
) (
  input  logic        i_clk_27_MHz,
  input  logic        i_rst_n,
  input  logic        i_sck,
  input  logic        i_cs_n,
  input  logic        i_mosi,
  output logic        o_miso,
  input  logic [7:0]  i_tx_data,
  input  logic        i_tx_valid,
  output logic        o_tx_ready,
  output logic [7:0]  o_rx_data,
  output logic        o_rx_valid,
  output logic [5:0]  o_cmd_idx,
  output logic [31:0] o_cmd_arg,
  output logic [6:0]  o_cmd_crc,
  output logic        o_cmd_crc_ok,
  output logic        o_cmd_valid
);

  typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_DONE} state_t;

  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sck_prev_q, cs_prev_q;
  logic                   sck_s, cs_s, mosi_s;
  logic                   sck_rise, sck_fall, cs_fall, reload, accept;
  logic [7:0]             reload_byte;

  logic [2:0]  bit_cnt_q;
  logic [7:0]  rx_sr_q, tx_sr_q, hold_q, rx_data_q;
  logic        hold_full_q, byte_done_q, rx_valid_q;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [5:0]  b0_q, b0_d;
  logic [31:0] arg_q, arg_d;
  logic [6:0]  crc_q, crc_d;
  logic        load_cmd;
  logic [5:0]  cmd_idx_q;
  logic [31:0] cmd_arg_q;
  logic [6:0]  cmd_crc_q;
  logic        cmd_ok_q;

  // Serial CRC7, polynomial x^7+x^3+1, applied MSB-first over one byte.
  function automatic logic [6:0] crc7_byte(input logic [6:0] crc_in, input logic [7:0] data);
    logic [6:0] c;
    logic       fb;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[6] ^ data[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sck_rise    = sck_s & ~sck_prev_q;
  assign sck_fall    = ~sck_s & sck_prev_q;
  assign cs_fall     = ~cs_s & cs_prev_q;
  // A fall with the counter at zero is the one that closes a completed byte.
  assign reload      = cs_fall | (~cs_s & sck_fall & (bit_cnt_q == 3'd0));
  assign reload_byte = hold_full_q ? hold_q : IDLE_FILL;
  assign accept      = i_tx_valid & ~hold_full_q;

  always_ff @(posedge i_clk_27_MHz) begin
    if (!i_rst_n) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '1;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], i_sck};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], i_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_mosi};
      sck_prev_q  <= sck_s;
      cs_prev_q   <= cs_s;
    end
  end

  always_ff @(posedge i_clk_27_MHz) begin
    if (!i_rst_n) begin
      bit_cnt_q   <= 3'd0;
      rx_sr_q     <= 8'd0;
      tx_sr_q     <= 8'hFF;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      byte_done_q <= 1'b0;
      rx_data_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
    end else begin
      rx_valid_q  <= byte_done_q;
      byte_done_q <= 1'b0;
      if (byte_done_q) rx_data_q <= rx_sr_q;
      if (cs_s) begin
        bit_cnt_q <= 3'd0;
        tx_sr_q   <= 8'hFF;
      end else begin
        if (sck_rise) begin
          rx_sr_q   <= {rx_sr_q[6:0], mosi_s};
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) byte_done_q <= 1'b1;
        end
        if (reload)        tx_sr_q <= reload_byte;
        else if (sck_fall) tx_sr_q <= {tx_sr_q[6:0], 1'b1};
      end
      if (reload && hold_full_q) hold_full_q <= 1'b0;
      if (accept) begin
        hold_q      <= i_tx_data;
        hold_full_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk_27_MHz) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 3'd0;
      b0_q      <= 6'd0;
      arg_q     <= 32'd0;
      crc_q     <= 7'd0;
      cmd_idx_q <= 6'd0;
      cmd_arg_q <= 32'd0;
      cmd_crc_q <= 7'd0;
      cmd_ok_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      b0_q    <= b0_d;
      arg_q   <= arg_d;
      crc_q   <= crc_d;
      if (load_cmd) begin
        cmd_idx_q <= b0_q;
        cmd_arg_q <= arg_q;
        cmd_crc_q <= rx_sr_q[7:1];
        cmd_ok_q  <= (rx_sr_q[7:1] == crc_q) && rx_sr_q[0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    b0_d     = b0_q;
    arg_d    = arg_q;
    crc_d    = crc_q;
    load_cmd = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (byte_done_q && (rx_sr_q[7:6] == 2'b01)) begin
          b0_d    = rx_sr_q[5:0];
          crc_d   = crc7_byte(7'd0, rx_sr_q);
          cnt_d   = 3'd1;
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (byte_done_q) begin
          if (cnt_q == 3'd5) begin
            load_cmd = 1'b1;
            state_d  = ST_DONE;
          end else begin
            arg_d = {arg_q[23:0], rx_sr_q};
            crc_d = crc7_byte(crc_q, rx_sr_q);
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Deselect abandons any frame in progress.
    if (cs_s) begin
      state_d  = ST_IDLE;
      load_cmd = 1'b0;
    end
  end

  assign o_miso       = tx_sr_q[7];
  assign o_tx_ready   = ~hold_full_q;
  assign o_rx_data    = rx_data_q;
  assign o_rx_valid   = rx_valid_q;
  assign o_cmd_idx    = cmd_idx_q;
  assign o_cmd_arg    = cmd_arg_q;
  assign o_cmd_crc    = cmd_crc_q;
  assign o_cmd_crc_ok = cmd_ok_q;
  assign o_cmd_valid  = (state_q == ST_DONE);

endmodule

// File: tb/tb_sd_spi_responder.sv
// Bench for sd_spi_responder: an SPI master drives bytes asynchronously while monitors
// compare received bytes and framed commands against a reference model's expectations.
module tb_sd_spi_responder;

  localparam int         SYNC_STAGES = 2;
  localparam logic [7:0] IDLE_FILL   = 8'hFF;

  logic        clk, rst_n, sck, cs_n, mosi, miso;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid;
  logic [5:0]  cmd_idx;
  logic [31:0] cmd_arg;
  logic [6:0]  cmd_crc;
  logic        cmd_crc_ok, cmd_valid;

  int checks = 0;
  int errors = 0;
  int half   = 200;

  logic [7:0]  exp_rx_q[$];
  logic [45:0] exp_cmd_q[$];

  // Reference model state: holding register, byte expected on MISO, frame assembly.
  bit          hold_full_m = 0;
  logic [7:0]  hold_m      = 8'h00;
  logic [7:0]  cur_tx_exp  = 8'hFF;
  logic [7:0]  frame_q[$];

  sd_spi_responder #(.SYNC_STAGES(SYNC_STAGES), .IDLE_FILL(IDLE_FILL)) dut (
    .i_clk_27_MHz(clk),
    .i_rst_n(rst_n),
    .i_sck(sck),
    .i_cs_n(cs_n),
    .i_mosi(mosi),
    .o_miso(miso),
    .i_tx_data(tx_data),
    .i_tx_valid(tx_valid),
    .o_tx_ready(tx_ready),
    .o_rx_data(rx_data),
    .o_rx_valid(rx_valid),
    .o_cmd_idx(cmd_idx),
    .o_cmd_arg(cmd_arg),
    .o_cmd_crc(cmd_crc),
    .o_cmd_crc_ok(cmd_crc_ok),
    .o_cmd_valid(cmd_valid)
  );

  initial clk = 1'b0;
  always #19 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // CRC7 as the remainder of (message * x^7) divided by x^7+x^3+1.
  function automatic logic [6:0] crc7_model(input logic [39:0] msg);
    logic [46:0] r;
    r = {msg, 7'd0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [7:0] consume();
    if (hold_full_m) begin
      hold_full_m = 0;
      return hold_m;
    end
    return IDLE_FILL;
  endfunction

  task automatic frame_model(input logic [7:0] b);
    logic [39:0] msg;
    logic [6:0]  rcrc;
    if (frame_q.size() == 0) begin
      if (b[7:6] == 2'b01) frame_q.push_back(b);
    end else begin
      frame_q.push_back(b);
      if (frame_q.size() == 6) begin
        msg  = {frame_q[0], frame_q[1], frame_q[2], frame_q[3], frame_q[4]};
        rcrc = b[7:1];
        exp_cmd_q.push_back({frame_q[0][5:0], msg[31:0], rcrc,
                             (rcrc == crc7_model(msg)) && b[0]});
        frame_q.delete();
      end
    end
  endtask

  task automatic tx_push(input logic [7:0] d, output bit done);
    done = 0;
    @(negedge clk);
    if (tx_ready) begin
      tx_valid = 1'b1;
      tx_data  = d;
      @(negedge clk);
      tx_valid = 1'b0;
      hold_m      = d;
      hold_full_m = 1;
      done        = 1;
      check("tx_ready_drop", tx_ready, 0);
    end
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    cur_tx_exp = consume();
    #300;
  endtask

  task automatic cs_high();
    #(half);
    cs_n = 1'b1;
    frame_q.delete();
    #400;
  endtask

  task automatic spi_byte(input logic [7:0] b, input bit push_mid);
    logic [7:0] got;
    bit         dn;
    exp_rx_q.push_back(b);
    frame_model(b);
    for (int i = 7; i >= 0; i--) begin
      mosi = b[i];
      #(half);
      got[i] = miso;
      sck = 1'b1;
      #(half);
      sck = 1'b0;
      if (push_mid && i == 4) tx_push(8'($urandom_range(0, 255)), dn);
    end
    check("miso_byte", got, cur_tx_exp);
    cur_tx_exp = consume();
  endtask

  task automatic send_frame(input logic [47:0] f);
    for (int i = 5; i >= 0; i--) spi_byte(f[i*8 +: 8], 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"}, miso, 1);
    check({tag, "_tx_ready"}, tx_ready, 1);
    check({tag, "_rx_data"}, rx_data, 0);
    check({tag, "_rx_valid"}, rx_valid, 0);
    check({tag, "_cmd_idx"}, cmd_idx, 0);
    check({tag, "_cmd_arg"}, cmd_arg, 0);
    check({tag, "_cmd_crc"}, cmd_crc, 0);
    check({tag, "_cmd_crc_ok"}, cmd_crc_ok, 0);
    check({tag, "_cmd_valid"}, cmd_valid, 0);
  endtask

  // Monitors: pop an expectation whenever the DUT presents a byte or a command.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rx_valid) begin
        if (exp_rx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: got %02h expected none", rx_data);
        end else begin
          e = exp_rx_q.pop_front();
          check("rx_byte", rx_data, e);
        end
      end
    end
  end

  initial begin
    logic [45:0] e;
    forever begin
      @(negedge clk);
      if (cmd_valid) begin
        if (exp_cmd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cmd_unexpected: got idx %0d arg %08h expected none", cmd_idx, cmd_arg);
        end else begin
          e = exp_cmd_q.pop_front();
          check("cmd_frame", {cmd_idx, cmd_arg, cmd_crc, cmd_crc_ok}, e);
        end
      end
    end
  end

  initial begin
    bit          dn;
    logic [7:0]  b;
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [7:0]  last;
    int          r, k, w;

    rst_n = 1'b0; sck = 1'b0; cs_n = 1'b1; mosi = 1'b1;
    tx_valid = 1'b0; tx_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // CMD0 at initialisation speed.
    half = 5000;
    cs_low();
    send_frame(48'h40_00_00_00_00_95);
    cs_high();

    half = 220;
    cs_low();
    send_frame(48'h48_00_00_01_AA_87);
    cs_high();
    cs_low();
    send_frame(48'h40_00_00_00_00_97);
    cs_high();

    // Preloaded response byte, then idle fill.
    tx_push(8'h01, dn);
    check("tx_accept", dn, 1);
    repeat (5) @(negedge clk);
    check("tx_ready_held", tx_ready, 0);
    cs_low();
    @(negedge clk);
    check("tx_ready_after_load", tx_ready, 1);
    spi_byte(8'hFF, 1'b0);
    spi_byte(8'hFF, 1'b0);
    cs_high();

    // Aborted frame followed by a full CMD17.
    cs_low();
    spi_byte(8'h51, 1'b0);
    spi_byte(8'h00, 1'b0);
    spi_byte(8'h00, 1'b0);
    cs_high();
    cs_low();
    send_frame(48'h51_00_00_02_00_55);
    cs_high();

    // Reset pulse in the middle of a byte, with a response byte pending.
    b = 8'hA5;
    cs_low();
    for (int i = 7; i >= 5; i--) begin
      mosi = b[i];
      #(half);
      sck = 1'b1;
      #(half);
      sck = 1'b0;
    end
    tx_push(8'h3C, dn);
    mosi = b[4];
    #(half);
    sck = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    hold_full_m = 0;
    frame_q.delete();
    check_reset_outputs("mid_rst");
    #(half);
    sck = 1'b0;
    cs_high();
    cs_low();
    spi_byte(8'h5A, 1'b0);
    cs_high();

    // Randomised sessions: frames with good or corrupt CRC, junk bytes, aborts, tx loads.
    for (int n = 0; n < 20; n++) begin
      half = $urandom_range(160, 300);
      if ($urandom_range(0, 3) == 0) tx_push(8'($urandom_range(0, 255)), dn);
      cs_low();
      k = $urandom_range(1, 3);
      for (int j = 0; j < k; j++) begin
        r = $urandom_range(0, 9);
        if (r < 6) begin
          idx  = 6'($urandom_range(0, 63));
          arg  = $urandom;
          last = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255))
                                             : {crc7_model({2'b01, idx, arg}), 1'b1};
          spi_byte({2'b01, idx}, $urandom_range(0, 2) == 0);
          for (int m = 3; m >= 0; m--) spi_byte(arg[m*8 +: 8], $urandom_range(0, 2) == 0);
          spi_byte(last, $urandom_range(0, 2) == 0);
        end else if (r < 8) begin
          spi_byte(8'($urandom_range(0, 255)), $urandom_range(0, 1) == 0);
        end else begin
          w = $urandom_range(1, 5);
          spi_byte({2'b01, 6'($urandom_range(0, 63))}, 1'b0);
          for (int m = 1; m < w; m++) spi_byte(8'($urandom_range(0, 255)), 1'b0);
          break;
        end
      end
      cs_high();
    end

    for (int t = 0; t < 200 && (exp_rx_q.size() != 0 || exp_cmd_q.size() != 0); t++)
      @(negedge clk);
    check("rx_queue_drained", exp_rx_q.size(), 0);
    check("cmd_queue_drained", exp_cmd_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
